// File: rtl/quad_decoder_pkg.sv
// Shared definitions for the quadrature decoder: FSM encoding, INIT length,
// Gray-code phase constants and the transition classifier.
package quad_decoder_pkg;

  typedef enum logic {ST_INIT = 1'b0, ST_TRACK = 1'b1} state_t;

  typedef enum logic [1:0] {TR_NONE, TR_UP, TR_DOWN, TR_ILLEGAL} trans_t;

  localparam int INIT_CYCLES = 3;
  localparam int SYNC_STAGES = 2;

  // Phase state is packed as {A,B}
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
    trans_t t;
    if (cur == prev)               t = TR_NONE;
    else if (cur == next_up(prev)) t = TR_UP;
    else if (prev == next_up(cur)) t = TR_DOWN;
    else                           t = TR_ILLEGAL;
    return t;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// Single-phase 2-flop synchronizer plus consecutive-sample debounce filter.
// The filter exists only when QUAD_DECODER_DEBOUNCE_EN is defined.
module quad_debounce
  import quad_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic bypass,
  input  logic raw,
  output logic filt
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;

  always_ff @(posedge clk) begin
    if (!reset) sync_chain <= '0;
    else        sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
  end

  assign sync = sync_chain[SYNC_STAGES-1];

`ifdef QUAD_DECODER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          filt_q;

  // While bypassed the filter tracks the synchronizer so it is aligned at TRACK entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      filt_q <= 1'b0;
    end else if (bypass) begin
      cnt    <= '0;
      filt_q <= sync;
    end else if (sync != filt_q) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt    <= '0;
        filt_q <= sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign filt = bypass ? sync : filt_q;
`else
  localparam int DEBOUNCE_UNUSED = DEBOUNCE_CYCLES;
  logic bypass_unused;
  assign bypass_unused = bypass;
  assign filt          = sync;
`endif

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: STEP/DIR pulse stream, wrapping POS count, ERR on
// double-phase jumps. Debounce filtering is enabled by QUAD_DECODER_DEBOUNCE_EN.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int POS_WIDTH       = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 QA,
  input  logic                 QB,
  output logic                 STEP,
  output logic                 DIR,
  output logic [POS_WIDTH-1:0] POS,
  output logic                 ERR
);

  state_t     state, state_nxt;
  logic [1:0] init_cnt;
  logic [1:0] filt;
  logic [1:0] prev;
  logic       bypass;
  trans_t     trans;

  assign bypass = (state == ST_INIT);

  quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(CLK), .reset(RESET), .bypass(bypass), .raw(QA), .filt(filt[1])
  );

  quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(CLK), .reset(RESET), .bypass(bypass), .raw(QB), .filt(filt[0])
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_cnt == 2'(INIT_CYCLES - 1)) state_nxt = ST_TRACK;
  end

  always_comb begin
    trans = TR_NONE;
    if (state == ST_TRACK) trans = classify(prev, filt);
  end

  // prev follows the filtered phase every clock, so INIT exit leaves it aligned
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      STEP <= 1'b0;
      ERR  <= 1'b0;
      DIR  <= 1'b0;
      POS  <= '0;
      prev <= PH_00;
    end else begin
      STEP <= (trans == TR_UP) || (trans == TR_DOWN);
      ERR  <= (trans == TR_ILLEGAL);
      prev <= filt;
      if (trans == TR_UP) begin
        DIR <= 1'b1;
        POS <= POS + POS_WIDTH'(1);
      end else if (trans == TR_DOWN) begin
        DIR <= 1'b0;
        POS <= POS - POS_WIDTH'(1);
      end
    end
  end

endmodule
